// File: rtl/ipark_arbiter.sv
// ipark_arbiter: round-robin arbiter and sequencer sharing one park_inverse
// datapath between two motor channels. A winner's operands are latched,
// the transform is enabled for LATENCY+1 cycles, and the result is returned
// to the winner with a one-cycle valid pulse.
module ipark_arbiter #(
   parameter int LATENCY = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] vd0,
   input  logic [15:0] vd1,
   input  logic [15:0] vq0,
   input  logic [15:0] vq1,
   input  logic [15:0] theta0,
   input  logic [15:0] theta1,
   output logic        ack0,
   output logic        ack1,
   output logic [63:0] res0,
   output logic [63:0] res1,
   output logic        res_valid0,
   output logic        res_valid1,
   output logic        ip_enable,
   output logic [31:0] ip_s_axis1,
   output logic [31:0] ip_s_axis2,
   input  logic [63:0] ip_m_axis,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // WAIT lasts LATENCY cycles: count from LATENCY-1 down to 0 inclusive.
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] vd_q, vd_d;
   logic [15:0] vq_q, vq_d;
   logic [15:0] theta_q, theta_d;
   logic        sel_q, sel_d;
   logic        last_q, last_d;
   logic [63:0] res0_q, res0_d;
   logic [63:0] res1_q, res1_d;
   logic        res_valid0_q, res_valid0_d;
   logic        res_valid1_q, res_valid1_d;
   logic        win;

   // State, operand, arbitration and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         vd_q         <= 16'd0;
         vq_q         <= 16'd0;
         theta_q      <= 16'd0;
         sel_q        <= 1'b0;
         last_q       <= 1'b1;   // channel 0 wins the first contention
         res0_q       <= 64'd0;
         res1_q       <= 64'd0;
         res_valid0_q <= 1'b0;
         res_valid1_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vd_q         <= vd_d;
         vq_q         <= vq_d;
         theta_q      <= theta_d;
         sel_q        <= sel_d;
         last_q       <= last_d;
         res0_q       <= res0_d;
         res1_q       <= res1_d;
         res_valid0_q <= res_valid0_d;
         res_valid1_q <= res_valid1_d;
      end
   end

   // Next-state logic: grant in IDLE, load the counter in ISSUE,
   // count down in WAIT and capture the result on the last cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      vd_d         = vd_q;
      vq_d         = vq_q;
      theta_d      = theta_q;
      sel_d        = sel_q;
      last_d       = last_q;
      res0_d       = res0_q;
      res1_d       = res1_q;
      res_valid0_d = 1'b0;
      res_valid1_d = 1'b0;
      // Channel 1 wins when it is the only requester, or when both request
      // and channel 0 was served last.
      win          = req1 & (~req0 | ~last_q);

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               vd_d    = win ? vd1 : vd0;
               vq_d    = win ? vq1 : vq0;
               theta_d = win ? theta1 : theta0;
               sel_d   = win;
               last_d  = win;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 8'd0) begin
               if (sel_q) begin
                  res1_d       = ip_m_axis;
                  res_valid1_d = 1'b1;
               end else begin
                  res0_d       = ip_m_axis;
                  res_valid0_d = 1'b1;
               end
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ack0       = (state_q == ISSUE) && !sel_q;
   assign ack1       = (state_q == ISSUE) && sel_q;
   assign ip_enable  = (state_q != IDLE);
   assign busy       = (state_q != IDLE);
   assign ip_s_axis1 = {vq_q, vd_q};
   assign ip_s_axis2 = {16'h0000, theta_q};
   assign res0       = res0_q;
   assign res1       = res1_q;
   assign res_valid0 = res_valid0_q;
   assign res_valid1 = res_valid1_q;

endmodule

// File: tb/tb_ipark_arbiter.sv
// Directed testbench for ipark_arbiter (LATENCY = 8). A small stub stands in
// for park_inverse: it presents the expected result only on the cycle where
// ip_enable has already been high for 8 cycles, garbage otherwise.
module tb_ipark_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1;
   logic [15:0] vd0, vd1, vq0, vq1, theta0, theta1;
   logic        ack0, ack1;
   logic [63:0] res0, res1;
   logic        res_valid0, res_valid1;
   logic        ip_enable;
   logic [31:0] ip_s_axis1, ip_s_axis2;
   logic [63:0] ip_m_axis;
   logic        busy;

   logic [63:0] stub_val;
   int          en_cnt;
   int          checks;
   int          errors;
   int          cyc;
   int          got;
   int          prev;
   logic [63:0] vals [3];

   ipark_arbiter #(.LATENCY(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .req1       (req1),
      .vd0        (vd0),
      .vd1        (vd1),
      .vq0        (vq0),
      .vq1        (vq1),
      .theta0     (theta0),
      .theta1     (theta1),
      .ack0       (ack0),
      .ack1       (ack1),
      .res0       (res0),
      .res1       (res1),
      .res_valid0 (res_valid0),
      .res_valid1 (res_valid1),
      .ip_enable  (ip_enable),
      .ip_s_axis1 (ip_s_axis1),
      .ip_s_axis2 (ip_s_axis2),
      .ip_m_axis  (ip_m_axis),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub: count consecutive enabled cycles.
   always @(posedge clk or negedge rst) begin
      if (!rst)           en_cnt <= 0;
      else if (ip_enable) en_cnt <= en_cnt + 1;
      else                en_cnt <= 0;
   end
   assign ip_m_axis = (en_cnt == 8) ? stub_val : 64'hDEAD_BEEF_DEAD_BEEF;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; prev = 0; got = 0;
      vals[0] = 64'h1000_2000_3000_4000;
      vals[1] = 64'h5555_6666_7777_8888;
      vals[2] = 64'h9999_AAAA_BBBB_CCCC;

      // ---------------- Reset with both requests high ----------------
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
      vd0 = 16'hFDA8; vq0 = 16'hFC28; theta0 = 16'h0064;
      vd1 = 16'h1111; vq1 = 16'h2222; theta1 = 16'h3333;
      stub_val = 64'h0123_4567_89AB_CDEF;
      repeat (3) step();
      $display("txn reset: checking idle outputs");
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_res0", res0, 0);
      chk("rst_res1", res1, 0);
      chk("rst_rv0", res_valid0, 0);
      chk("rst_rv1", res_valid1, 0);
      chk("rst_en", ip_enable, 0);
      chk("rst_s1", ip_s_axis1, 0);
      chk("rst_s2", ip_s_axis2, 0);
      chk("rst_busy", busy, 0);

      // ---------------- Single transaction (first grant ch0) ----------
      rst = 1'b1;                 // cycle 0
      step();                     // cycle 1
      $display("txn single ch0: ack0=%0b ack1=%0b", ack0, ack1);
      chk("single_ack0", ack0, 1);
      chk("single_ack1", ack1, 0);
      chk("single_en_c1", ip_enable, 1);
      chk("single_busy_c1", busy, 1);
      chk("single_s1_c1", ip_s_axis1, 32'hFC28_FDA8);
      chk("single_s2_c1", ip_s_axis2, 32'h0000_0064);
      req0 = 1'b0; req1 = 1'b0;
      vd0 = 16'h0BAD; vq0 = 16'h0BAD; theta0 = 16'h0BAD;
      for (int c = 2; c <= 9; c++) begin
         step();
         chk("single_en", ip_enable, 1);
         chk("single_s1", ip_s_axis1, 32'hFC28_FDA8);
         chk("single_s2", ip_s_axis2, 32'h0000_0064);
         chk("single_noack", ack0, 0);
         chk("single_norv", res_valid0, 0);
      end
      step();                     // cycle 10
      $display("txn single ch0 result: rv0=%0b res0=%h", res_valid0, res0);
      chk("single_en_c10", ip_enable, 0);
      chk("single_busy_c10", busy, 0);
      chk("single_rv0", res_valid0, 1);
      chk("single_res0", res0, 64'h0123_4567_89AB_CDEF);
      chk("single_rv1", res_valid1, 0);
      chk("single_res1", res1, 0);
      step();                     // cycle 11
      chk("single_rv0_drop", res_valid0, 0);
      chk("single_res0_hold", res0, 64'h0123_4567_89AB_CDEF);

      // ---------------- Late arrival of ch1 ----------------
      req0 = 1'b1; vd0 = 16'h1234; vq0 = 16'h5678; theta0 = 16'h0ABC;
      stub_val = 64'hA5A5_0000_1111_2222;
      step();                     // cycle 1
      chk("late_ack0", ack0, 1);
      chk("late_s1", ip_s_axis1, 32'h5678_1234);
      chk("late_s2", ip_s_axis2, 32'h0000_0ABC);
      req0 = 1'b0;
      for (int c = 2; c <= 9; c++) begin
         step();
         if (c == 4) req1 = 1'b1;
         chk("late_ack1_wait", ack1, 0);
         chk("late_rv0_wait", res_valid0, 0);
      end
      step();                     // cycle 10
      $display("txn late ch0 result: rv0=%0b res0=%h", res_valid0, res0);
      chk("late_rv0", res_valid0, 1);
      chk("late_res0", res0, 64'hA5A5_0000_1111_2222);
      chk("late_ack1_c10", ack1, 0);
      stub_val = 64'h5A5A_FFFF_3333_4444;
      step();                     // cycle 11
      $display("txn late ch1 grant: ack1=%0b", ack1);
      chk("late_ack1", ack1, 1);
      chk("late_ack0_c11", ack0, 0);
      chk("late_s1_ch1", ip_s_axis1, 32'h2222_1111);
      chk("late_s2_ch1", ip_s_axis2, 32'h0000_3333);
      req1 = 1'b0;
      for (int c = 12; c <= 19; c++) begin
         step();
         chk("late_rv1_wait", res_valid1, 0);
      end
      step();                     // cycle 20
      $display("txn late ch1 result: rv1=%0b res1=%h", res_valid1, res1);
      chk("late_rv1", res_valid1, 1);
      chk("late_res1", res1, 64'h5A5A_FFFF_3333_4444);
      chk("late_res0_hold", res0, 64'hA5A5_0000_1111_2222);
      chk("late_rv0_quiet", res_valid0, 0);

      // ---------------- Contention (last = ch1, so ch0 first) --------
      req0 = 1'b1; req1 = 1'b1;
      for (int g = 0; g < 4; g++) begin
         got = -1;
         for (int k = 0; k < 12 && got < 0; k++) begin
            step();
            if (ack0) got = 0;
            else if (ack1) got = 1;
         end
         $display("txn contention grant %0d: channel %0d at cycle %0d", g, got, cyc);
         chk("cont_grant", got, g % 2);
         if (g > 0) chk("cont_gap", cyc - prev, 10);
         prev = cyc;
         if (got == 0) req0 = 1'b0;
         else if (got == 1) req1 = 1'b0;
         if (g < 3) begin
            step();
            req0 = 1'b1; req1 = 1'b1;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 12 && busy; k++) step();
      chk("cont_idle", busy, 0);

      // ---------------- Reset mid-WAIT ----------------
      req0 = 1'b1; stub_val = 64'h1111_2222_3333_4444;
      step();                     // cycle 1
      chk("rmid_ack0", ack0, 1);
      req0 = 1'b0;
      repeat (4) step();          // cycle 5, fourth WAIT cycle
      rst = 1'b0;
      #1;
      $display("txn reset mid-wait: en=%0b busy=%0b res0=%h", ip_enable, busy, res0);
      chk("rmid_en", ip_enable, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_res0", res0, 0);
      chk("rmid_res1", res1, 0);
      chk("rmid_rv0", res_valid0, 0);
      repeat (2) step();
      chk("rmid_rv0_hold", res_valid0, 0);
      rst = 1'b1;                 // cycle 0 of a fresh request
      req0 = 1'b1; vd0 = 16'h0102; vq0 = 16'h0304; theta0 = 16'h0506;
      stub_val = 64'hFEDC_BA98_7654_3210;
      step();                     // cycle 1
      chk("rmid2_ack0", ack0, 1);
      chk("rmid2_s1", ip_s_axis1, 32'h0304_0102);
      req0 = 1'b0;
      for (int c = 2; c <= 9; c++) begin
         step();
         chk("rmid2_norv", res_valid0, 0);
      end
      step();                     // cycle 10
      $display("txn after reset ch0 result: rv0=%0b res0=%h", res_valid0, res0);
      chk("rmid2_rv0", res_valid0, 1);
      chk("rmid2_res0", res0, 64'hFEDC_BA98_7654_3210);

      // ---------------- Back-to-back ch0 ----------------
      req0 = 1'b1;
      for (int t = 0; t < 3; t++) begin
         step();                  // cycle 1
         chk("b2b_ack0", ack0, 1);
         req0 = 1'b0;
         stub_val = vals[t];
         step();                  // cycle 2
         req0 = (t < 2);
         repeat (7) step();       // cycle 9
         chk("b2b_norv", res_valid0, 0);
         step();                  // cycle 10
         $display("txn back-to-back %0d: rv0=%0b res0=%h", t, res_valid0, res0);
         chk("b2b_rv0", res_valid0, 1);
         chk("b2b_res0", res0, vals[t]);
      end
      step();
      chk("b2b_rv0_drop", res_valid0, 0);
      chk("b2b_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
